// File: rtl/fmax_job_feeder.sv
// Job feeder for the find-maximum unit: FIFO of operand entries replayed as start + N valid beats.
// Optional FMAX_FEEDER_ERR_EN adds a sticky err flag (overflow write or job_go while busy).
module fmax_job_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_data_A,
  input  logic [7:0]    wr_data_B,
  input  logic [7:0]    wr_data_C,
  input  logic [7:0]    wr_instruction,
  input  logic [2:0]    wr_select,
  input  logic          job_go,
  input  logic [2:0]    job_count,
  output logic          busy,
  output logic          job_done,
  output logic [AW:0]   fifo_level,
  output logic          start,
  output logic [2:0]    count,
  output logic          valid,
  output logic [7:0]    data_A,
  output logic [7:0]    data_B,
  output logic [7:0]    data_C,
  output logic [7:0]    instruction,
  output logic [2:0]    select
`ifdef FMAX_FEEDER_ERR_EN
  ,
  input  logic          err_clr,
  output logic          err
`endif
);

  localparam int EW = 35;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, ISSUE, DONE} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [2:0]    count_q, count_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [EW-1:0] beat_q, beat_d;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign wr_ready = ~full & ~rst;
  assign push     = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_data_A, wr_data_B, wr_data_C, wr_instruction, wr_select};
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Registered outputs are computed one edge early so each reflects the state it is shown in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    count_d = count_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    beat_d  = beat_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_go) begin
          state_d = START;
          start_d = 1'b1;
          count_d = job_count;
          cnt_d   = (job_count == 3'd0) ? 4'd8 : {1'b0, job_count};
        end
      end
      START: begin
        state_d = ISSUE;
        pop     = ~empty;
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          pop = ~empty;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      valid_d = 1'b1;
      beat_d  = mem_q[rd_ptr_q];
      cnt_d   = cnt_q - 4'd1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      beat_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FMAX_FEEDER_ERR_EN
  logic err_q, err_d, err_set;

  // A set event in the same cycle as err_clr keeps the flag raised.
  always_comb begin
    err_set = (wr_valid & full) | (job_go & (state_q != IDLE));
    err_d   = err_q;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign busy        = busy_q;
  assign job_done    = done_q;
  assign fifo_level  = level_q;
  assign start       = start_q;
  assign count       = count_q;
  assign valid       = valid_q;
  assign data_A      = beat_q[34:27];
  assign data_B      = beat_q[26:19];
  assign data_C      = beat_q[18:11];
  assign instruction = beat_q[10:3];
  assign select      = beat_q[2:0];

endmodule
